// File: rtl/ctrl_tx_arbiter.sv
`timescale 1ns/1ps
// ctrl_tx_arbiter: shares the outgoing control-packet AXI-Stream channel
// between NUM_REQ sources (0 = listen handshake, 1 = close shutdown,
// 2 = EXP keep-alive). Whole packets are granted round-robin with a
// one-cycle bubble. A beat-count watchdog truncates runaway packets and
// drains the rest of them.
// Optional build macro: CTRL_ARB_SHUTDOWN_PRIO_EN (port 1 wins in IDLE).
//
// Handshake: a beat moves on an interface when tvalid & tready are both high
// at a rising edge. Once tvalid is raised, the source holds tdata/tkeep/tlast
// stable until that beat moves. The arbiter has no storage, so while the
// channel is stalled the m_* outputs simply follow the granted source.
module ctrl_tx_arbiter #(
    parameter int DATA_W    = 64,
    parameter int KEEP_W    = 8,
    parameter int NUM_REQ   = 3,
    parameter int MAX_BEATS = 16
) (
    input  logic                      core_clk,
    input  logic                      core_rst,
    input  logic [NUM_REQ*DATA_W-1:0] s_tdata_i,
    input  logic [NUM_REQ*KEEP_W-1:0] s_tkeep_i,
    input  logic [NUM_REQ-1:0]        s_tvalid_i,
    input  logic [NUM_REQ-1:0]        s_tlast_i,
    output logic [NUM_REQ-1:0]        s_tready_o,
    output logic [DATA_W-1:0]         m_tdata_o,
    output logic [KEEP_W-1:0]         m_tkeep_o,
    output logic                      m_tvalid_o,
    output logic                      m_tlast_o,
    input  logic                      m_tready_i,
    output logic [NUM_REQ-1:0]        grant_o,
    output logic                      busy_o,
    output logic                      trunc_o
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]      gidx_q, gidx_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]      beat_cnt_q, beat_cnt_d;
    logic               trunc_q, trunc_d;

    logic               sel_found;
    logic [PW-1:0]      sel_idx;
    logic [PW-1:0]      cand;
    logic [DATA_W-1:0]  g_data;
    logic [KEEP_W-1:0]  g_keep;
    logic               g_valid;
    logic               g_last;
    logic               at_limit;
    logic [PW-1:0]      next_ptr;

    // Pick the first valid requester starting at rr_ptr (optionally port 1 first).
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        // Walk downwards so the lowest offset from rr_ptr is written last and wins.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = PW'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (s_tvalid_i[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
`ifdef CTRL_ARB_SHUTDOWN_PRIO_EN
        if (s_tvalid_i[1]) begin
            sel_found = 1'b1;
            sel_idx   = PW'(1);
        end
`endif
    end

    // Mux out the signals of the currently granted source.
    always_comb begin
        g_data  = '0;
        g_keep  = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gidx_q == PW'(k)) begin
                g_data  = s_tdata_i[k*DATA_W +: DATA_W];
                g_keep  = s_tkeep_i[k*KEEP_W +: KEEP_W];
                g_valid = s_tvalid_i[k];
                g_last  = s_tlast_i[k];
            end
        end
    end

    assign at_limit = (beat_cnt_q == CW'(MAX_BEATS - 1));
    assign next_ptr = (gidx_q == PW'(NUM_REQ - 1)) ? '0 : gidx_q + PW'(1);

    // Next-state and output logic of the grant FSM.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        trunc_d    = 1'b0;
        s_tready_o = '0;
        m_tdata_o  = '0;
        m_tkeep_o  = '0;
        m_tvalid_o = 1'b0;
        m_tlast_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    state_d    = ST_XFER;
                    gidx_d     = sel_idx;
                    grant_d    = NUM_REQ'(1) << sel_idx;
                    beat_cnt_d = '0;
                end
            end
            ST_XFER: begin
                m_tdata_o  = g_data;
                m_tkeep_o  = g_keep;
                m_tvalid_o = g_valid;
                m_tlast_o  = g_last | at_limit;
                s_tready_o = NUM_REQ'(m_tready_i) << gidx_q;
                if (g_valid && m_tready_i) begin
                    if (g_last) begin
                        state_d    = ST_IDLE;
                        grant_d    = '0;
                        beat_cnt_d = '0;
`ifdef CTRL_ARB_SHUTDOWN_PRIO_EN
                        if (gidx_q != PW'(1)) rr_ptr_d = next_ptr;
`else
                        rr_ptr_d   = next_ptr;
`endif
                    end else if (at_limit) begin
                        // Forced tlast went out; swallow the rest of this packet.
                        state_d    = ST_DRAIN;
                        trunc_d    = 1'b1;
                        beat_cnt_d = beat_cnt_q + CW'(1);
                    end else begin
                        beat_cnt_d = beat_cnt_q + CW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                s_tready_o = NUM_REQ'(1) << gidx_q;
                if (g_valid && g_last) begin
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                    beat_cnt_d = '0;
`ifdef CTRL_ARB_SHUTDOWN_PRIO_EN
                    if (gidx_q != PW'(1)) rr_ptr_d = next_ptr;
`else
                    rr_ptr_d   = next_ptr;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            trunc_q    <= trunc_d;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q != ST_IDLE);
    assign trunc_o = trunc_q;

endmodule

// File: tb/tb_ctrl_tx_arbiter.sv
`timescale 1ns/1ps
// Directed bench for ctrl_tx_arbiter (MAX_BEATS reduced to 4 so the
// watchdog is reachable with short packets).
module tb_ctrl_tx_arbiter;

    localparam int DW = 64;
    localparam int KW = 8;
    localparam int NR = 3;
    localparam int MB = 4;

    // clock / reset
    logic core_clk = 1'b0;
    logic core_rst = 1'b1;
    always #5 core_clk = ~core_clk;

    logic [NR*DW-1:0] s_tdata_i = '0;
    logic [NR*KW-1:0] s_tkeep_i = '0;
    logic [NR-1:0]    s_tvalid_i = '0;
    logic [NR-1:0]    s_tlast_i = '0;
    logic [NR-1:0]    s_tready_o;
    logic [DW-1:0]    m_tdata_o;
    logic [KW-1:0]    m_tkeep_o;
    logic             m_tvalid_o;
    logic             m_tlast_o;
    logic             m_tready_i = 1'b1;
    logic [NR-1:0]    grant_o;
    logic             busy_o;
    logic             trunc_o;

    ctrl_tx_arbiter #(
        .DATA_W(DW), .KEEP_W(KW), .NUM_REQ(NR), .MAX_BEATS(MB)
    ) dut (
        .core_clk  (core_clk),
        .core_rst  (core_rst),
        .s_tdata_i (s_tdata_i),
        .s_tkeep_i (s_tkeep_i),
        .s_tvalid_i(s_tvalid_i),
        .s_tlast_i (s_tlast_i),
        .s_tready_o(s_tready_o),
        .m_tdata_o (m_tdata_o),
        .m_tkeep_o (m_tkeep_o),
        .m_tvalid_o(m_tvalid_o),
        .m_tlast_o (m_tlast_o),
        .m_tready_i(m_tready_i),
        .grant_o   (grant_o),
        .busy_o    (busy_o),
        .trunc_o   (trunc_o)
    );

    // source models: packet k emits base[k] + beat index, tlast on its last beat
    int            pkt_len  [NR];
    int            beat_idx [NR];
    logic          active   [NR];
    logic [DW-1:0] base     [NR];
    logic [NR-1:0] hs;
    int            out_beats = 0;
    int            errors = 0;
    int            checks = 0;

    logic [2:0]    exp_g [9];
    logic          exp_v [9];
    logic [DW-1:0] exp_d [9];
    logic          exp_l [9];
    logic [DW-1:0] bp_d  [7];
    logic          bp_l  [7];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_ports();
        for (int k = 0; k < NR; k++) begin
            s_tvalid_i[k]            = active[k];
            s_tlast_i[k]             = (beat_idx[k] == pkt_len[k] - 1);
            s_tdata_i[k*DW +: DW]    = base[k] + DW'(beat_idx[k]);
            s_tkeep_i[k*KW +: KW]    = 8'hF0 | KW'(k);
        end
    endtask

    task automatic start_pkt(input int k, input int len, input logic [DW-1:0] b);
        active[k]   = 1'b1;
        pkt_len[k]  = len;
        beat_idx[k] = 0;
        base[k]     = b;
        drive_ports();
    endtask

    // one clock: record handshakes before the edge, advance sources after it
    task automatic step();
        #1;
        hs = s_tvalid_i & s_tready_o;
        if (m_tvalid_o && m_tready_i) out_beats++;
        @(posedge core_clk);
        #1;
        for (int k = 0; k < NR; k++) begin
            if (hs[k] === 1'b1) begin
                if (beat_idx[k] == pkt_len[k] - 1) active[k] = 1'b0;
                beat_idx[k]++;
            end
        end
        drive_ports();
        #1;
    endtask

    initial begin
        exp_g = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b010, 3'b000, 3'b100, 3'b100, 3'b000};
        exp_v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_d = '{64'h10, 64'h11, 64'h0, 64'h20, 64'h21, 64'h0, 64'h30, 64'h31, 64'h0};
        exp_l = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        bp_d  = '{64'h40, 64'h41, 64'h41, 64'h42, 64'h42, 64'h43, 64'h43};
        bp_l  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        // reset with every source requesting
        for (int k = 0; k < NR; k++) start_pkt(k, 100, 64'h0);
        core_rst = 1'b1;
        step();
        step();
        chk("rst_tready", s_tready_o, 3'b000);
        chk("rst_tvalid", m_tvalid_o, 1'b0);
        chk("rst_grant",  grant_o,    3'b000);
        chk("rst_busy",   busy_o,     1'b0);
        chk("rst_trunc",  trunc_o,    1'b0);
        chk("rst_tdata",  m_tdata_o,  64'h0);
        for (int k = 0; k < NR; k++) active[k] = 1'b0;
        drive_ports();
        core_rst = 1'b0;
        step();
        chk("idle_grant", grant_o, 3'b000);

`ifdef CTRL_ARB_SHUTDOWN_PRIO_EN
        // port 1 beats round-robin order and does not move the pointer
        start_pkt(0, 1, 64'h70);
        start_pkt(1, 1, 64'h71);
        step();
        chk("prio_grant1", grant_o, 3'b010);
        chk("prio_data1",  m_tdata_o, 64'h71);
        step();
        chk("prio_bubble", grant_o, 3'b000);
        start_pkt(2, 1, 64'h72);
        step();
        chk("prio_grant0", grant_o, 3'b001);
        chk("prio_data0",  m_tdata_o, 64'h70);
        step();
        step();
        chk("prio_grant2", grant_o, 3'b100);
        chk("prio_data2",  m_tdata_o, 64'h72);
`else
        // single 3-beat packet on port 1
        start_pkt(1, 3, 64'hA1);
        #1;
        chk("t1_pre_tvalid", m_tvalid_o, 1'b0);
        chk("t1_pre_tready", s_tready_o, 3'b000);
        step();
        chk("t1_grant",  grant_o,    3'b010);
        chk("t1_tready", s_tready_o, 3'b010);
        chk("t1_busy",   busy_o,     1'b1);
        chk("t1_d0",     m_tdata_o,  64'hA1);
        chk("t1_keep",   m_tkeep_o,  8'hF1);
        chk("t1_l0",     m_tlast_o,  1'b0);
        step();
        chk("t1_d1", m_tdata_o, 64'hA2);
        chk("t1_l1", m_tlast_o, 1'b0);
        step();
        chk("t1_d2", m_tdata_o, 64'hA3);
        chk("t1_l2", m_tlast_o, 1'b1);
        step();
        chk("t1_end_grant",  grant_o,    3'b000);
        chk("t1_end_tvalid", m_tvalid_o, 1'b0);
        chk("t1_end_busy",   busy_o,     1'b0);

        // all ports request: pointer sits at 2 after port 1
        start_pkt(0, 2, 64'h10);
        start_pkt(1, 2, 64'h20);
        start_pkt(2, 1, 64'hC1);
        step();
        chk("t2_grant", grant_o,   3'b100);
        chk("t2_data",  m_tdata_o, 64'hC1);
        chk("t2_last",  m_tlast_o, 1'b1);
        step();
        chk("t2_bubble", m_tvalid_o, 1'b0);

        // contention from pointer 0: order 0,1,2 with one idle cycle between
        start_pkt(2, 2, 64'h30);
        out_beats = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            chk($sformatf("t3_grant_%0d", i),  grant_o,    exp_g[i]);
            chk($sformatf("t3_tvalid_%0d", i), m_tvalid_o, exp_v[i]);
            chk($sformatf("t3_tdata_%0d", i),  m_tdata_o,  exp_d[i]);
            chk($sformatf("t3_tlast_%0d", i),  m_tlast_o,  exp_l[i]);
        end
        chk("t3_beats", out_beats, 6);

        // backpressure on a 4-beat packet from port 0
        out_beats = 0;
        start_pkt(0, 4, 64'h40);
        step();
        for (int i = 0; i < 7; i++) begin
            m_tready_i = ((i % 2) == 0);
            #1;
            chk($sformatf("t4_tready_%0d", i), s_tready_o, {2'b00, m_tready_i});
            chk($sformatf("t4_tdata_%0d", i),  m_tdata_o,  bp_d[i]);
            chk($sformatf("t4_tlast_%0d", i),  m_tlast_o,  bp_l[i]);
            step();
        end
        m_tready_i = 1'b1;
        #1;
        chk("t4_end_grant", grant_o,   3'b000);
        chk("t4_no_trunc",  trunc_o,   1'b0);
        chk("t4_beats",     out_beats, 4);

        // watchdog: 6-beat packet on port 2, only 4 leave
        out_beats = 0;
        start_pkt(2, 6, 64'h50);
        step();
        chk("t5_grant", grant_o,   3'b100);
        chk("t5_d0",    m_tdata_o, 64'h50);
        step();
        chk("t5_d1",    m_tdata_o, 64'h51);
        step();
        chk("t5_d2",    m_tdata_o, 64'h52);
        chk("t5_l2",    m_tlast_o, 1'b0);
        step();
        chk("t5_d3",       m_tdata_o, 64'h53);
        chk("t5_forced_l", m_tlast_o, 1'b1);
        chk("t5_trunc_lo", trunc_o,   1'b0);
        step();
        chk("t5_trunc_hi",   trunc_o,    1'b1);
        chk("t5_drain_tv",   m_tvalid_o, 1'b0);
        chk("t5_drain_rdy",  s_tready_o, 3'b100);
        chk("t5_drain_busy", busy_o,     1'b1);
        step();
        chk("t5_trunc_pulse", trunc_o,    1'b0);
        chk("t5_drain_tv2",   m_tvalid_o, 1'b0);
        step();
        chk("t5_idle_busy", busy_o,      1'b0);
        chk("t5_beats",     out_beats,   4);
        chk("t5_absorbed",  beat_idx[2], 6);
        start_pkt(0, 1, 64'h60);
        start_pkt(1, 1, 64'h61);
        start_pkt(2, 1, 64'h62);
        step();
        chk("t5_rr_zero", grant_o,   3'b001);
        chk("t5_rr_data", m_tdata_o, 64'h60);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
